// File: rtl/mod_updown_counter.sv
// mod_updown_counter: modulo-N up/down counter with load, run-once stop and cascade carry
module mod_updown_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up,
    input  logic             one_shot,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             carry_out,
    output logic             stopped
);
    if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_bad_modulus
        $error("mod_updown_counter: MODULUS out of range for WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);

    typedef enum logic {RUN, STOP} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] count_n, term;
    logic             at_term, step;

    // terminal value follows the current direction; the carry fires on wrap or terminate edges
    always_comb begin
        term      = up ? MAX : '0;
        at_term   = count == term;
        step      = enable & (state == RUN);
        carry_out = step & at_term & ~load & ~reset;
        count_n   = load ? ((load_value > MAX) ? MAX : load_value)
                  : !step ? count
                  : at_term ? (one_shot ? count : (up ? '0 : MAX))
                  : up ? count + 1'b1 : count - 1'b1;
        state_n   = load ? RUN : (step & at_term & one_shot) ? STOP : state;
    end

    // count, state and stopped flag registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RUN;
            count   <= '0;
            stopped <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            stopped <= state_n == STOP;
        end
    end
endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter: scoreboard bench for single, cascaded and full-range counters
module tb_mod_updown_counter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       m_rst = 0, m_ld = 0, m_en = 0, m_up = 0, m_os = 0;
    logic [3:0] m_lv = 0, m_count;
    logic       m_carry, m_stopped;

    logic       c_rst = 0, c_en = 0;
    logic [3:0] u_count, t_count;
    logic       u_carry, u_stopped, t_carry, t_stopped;

    logic       w_rst = 0, w_ld = 0, w_en = 0, w_up = 0;
    logic [3:0] w_lv = 0, w_count;
    logic       w_carry, w_stopped;

    mod_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk(clk), .reset(m_rst), .enable(m_en), .up(m_up), .one_shot(m_os),
        .load(m_ld), .load_value(m_lv), .count(m_count), .carry_out(m_carry), .stopped(m_stopped));

    mod_updown_counter #(.WIDTH(4), .MODULUS(10)) units (
        .clk(clk), .reset(c_rst), .enable(c_en), .up(1'b1), .one_shot(1'b0),
        .load(1'b0), .load_value(4'd0), .count(u_count), .carry_out(u_carry), .stopped(u_stopped));

    mod_updown_counter #(.WIDTH(4), .MODULUS(10)) tens (
        .clk(clk), .reset(c_rst), .enable(u_carry), .up(1'b1), .one_shot(1'b0),
        .load(1'b0), .load_value(4'd0), .count(t_count), .carry_out(t_carry), .stopped(t_stopped));

    mod_updown_counter #(.WIDTH(4), .MODULUS(16)) wide (
        .clk(clk), .reset(w_rst), .enable(w_en), .up(w_up), .one_shot(1'b0),
        .load(w_ld), .load_value(w_lv), .count(w_count), .carry_out(w_carry), .stopped(w_stopped));

    typedef struct {
        int         sel;
        logic       carry;
        logic [7:0] cnt;
        logic       st;
        string      name;
    } item_t;

    item_t q[$];
    int    n_checks = 0;
    int    n_fail = 0;

    task automatic push(input int sel, input logic ec, input logic [7:0] ecnt, input logic est, input string nm);
        item_t it;
        it.sel = sel; it.carry = ec; it.cnt = ecnt; it.st = est; it.name = nm;
        q.push_back(it);
    endtask

    task automatic mstep(input logic rst, input logic ld, input logic en, input logic u, input logic os,
                         input logic [3:0] lv, input logic ec, input logic [3:0] ecnt, input logic est,
                         input string nm);
        @(negedge clk);
        m_rst = rst; m_ld = ld; m_en = en; m_up = u; m_os = os; m_lv = lv;
        push(0, ec, {4'd0, ecnt}, est, nm);
    endtask

    task automatic cstep(input logic rst, input logic en, input logic ec, input logic [7:0] ecnt, input string nm);
        @(negedge clk);
        c_rst = rst; c_en = en;
        push(1, ec, ecnt, 1'b0, nm);
    endtask

    task automatic wstep(input logic rst, input logic ld, input logic en, input logic u, input logic [3:0] lv,
                         input logic ec, input logic [3:0] ecnt, input string nm);
        @(negedge clk);
        w_rst = rst; w_ld = ld; w_en = en; w_up = u; w_lv = lv;
        push(2, ec, {4'd0, ecnt}, 1'b0, nm);
    endtask

    // monitor: carry checked before the edge, count/stopped checked just after it
    initial begin
        item_t      it;
        logic       a_carry, a_st;
        logic [7:0] a_cnt;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                it = q.pop_front();
                a_carry = it.sel == 0 ? m_carry : it.sel == 1 ? t_carry : w_carry;
                n_checks++;
                if (a_carry !== it.carry) begin
                    n_fail++;
                    $display("FAIL %s carry: got %b want %b", it.name, a_carry, it.carry);
                end
                @(posedge clk);
                #1;
                a_cnt = it.sel == 0 ? {4'd0, m_count} : it.sel == 1 ? {t_count, u_count} : {4'd0, w_count};
                a_st  = it.sel == 0 ? m_stopped : it.sel == 1 ? t_stopped : w_stopped;
                n_checks++;
                if (a_cnt !== it.cnt) begin
                    n_fail++;
                    $display("FAIL %s count: got %0h want %0h", it.name, a_cnt, it.cnt);
                end
                n_checks++;
                if (a_st !== it.st) begin
                    n_fail++;
                    $display("FAIL %s stopped: got %b want %b", it.name, a_st, it.st);
                end
            end
        end
    end

    initial begin
        mstep(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        for (int i = 0; i < 12; i++)
            mstep(0, 0, 1, 1, 0, 0, (i % 10) == 9, 4'((i + 1) % 10), 0, "wrap_up");
        mstep(0, 1, 0, 0, 0, 15, 0, 9, 0, "load_clamp15");
        for (int i = 0; i < 10; i++)
            mstep(0, 0, 1, 0, 0, 0, i == 9, (i < 9) ? 4'(8 - i) : 4'd9, 0, "wrap_down");
        mstep(0, 1, 1, 1, 1, 7, 0, 7, 0, "load7_kills_carry");
        mstep(0, 0, 1, 1, 1, 0, 0, 8, 0, "oneshot_7to8");
        mstep(0, 0, 1, 1, 1, 0, 0, 9, 0, "oneshot_8to9");
        mstep(0, 0, 1, 1, 1, 0, 1, 9, 1, "oneshot_terminate");
        mstep(0, 0, 1, 1, 1, 0, 0, 9, 1, "stop_hold");
        mstep(0, 0, 1, 0, 0, 0, 0, 9, 1, "stop_hold_down");
        mstep(0, 1, 0, 1, 0, 3, 0, 3, 0, "load3_exit_stop");
        mstep(0, 0, 1, 1, 0, 0, 0, 4, 0, "resume_3to4");
        mstep(0, 0, 1, 1, 0, 0, 0, 5, 0, "resume_4to5");
        mstep(0, 1, 1, 1, 0, 2, 0, 2, 0, "load_beats_enable");
        mstep(0, 0, 1, 1, 0, 0, 0, 3, 0, "count_2to3");
        mstep(0, 0, 1, 1, 0, 0, 0, 4, 0, "count_3to4");
        mstep(0, 0, 1, 1, 0, 0, 0, 5, 0, "count_4to5");
        mstep(0, 0, 1, 1, 0, 0, 0, 6, 0, "count_5to6");
        mstep(1, 0, 1, 1, 0, 0, 0, 0, 0, "reset_midcount");
        mstep(0, 0, 1, 0, 0, 0, 1, 9, 0, "flip_down_0to9");
        mstep(0, 0, 1, 1, 0, 0, 1, 0, 0, "flip_up_9to0");
        mstep(0, 0, 1, 0, 1, 0, 1, 0, 1, "oneshot_down_stop");
        mstep(1, 0, 1, 0, 1, 0, 0, 0, 0, "reset_from_stop");
        mstep(0, 0, 1, 1, 0, 0, 0, 1, 0, "run_after_reset");
        mstep(0, 0, 0, 1, 0, 0, 0, 1, 0, "hold_disabled");
        mstep(0, 1, 0, 1, 0, 10, 0, 9, 0, "load_clamp10");
        mstep(0, 0, 0, 1, 0, 0, 0, 9, 0, "hold_at_term");

        cstep(1, 0, 0, 8'h00, "bcd_reset");
        for (int k = 0; k <= 100; k++)
            cstep(0, 1, k == 99, {4'(((k + 1) % 100) / 10), 4'((k + 1) % 10)}, "bcd");
        cstep(0, 0, 0, 8'h01, "bcd_hold");

        wstep(1, 0, 0, 0, 0, 0, 0, "w16_reset");
        wstep(0, 1, 0, 1, 14, 0, 14, "w16_load14");
        wstep(0, 0, 1, 1, 0, 0, 15, "w16_14to15");
        wstep(0, 0, 1, 1, 0, 1, 0, "w16_wrap_up");
        wstep(0, 0, 1, 0, 0, 1, 15, "w16_wrap_down");
        wstep(0, 0, 1, 0, 0, 0, 14, "w16_15to14");
        wstep(0, 1, 0, 0, 15, 0, 15, "w16_load15_noclamp");

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
